icon_sprite: RTL and testbench
==============================

ICON_SPRITE -- requirements
Module: icon_sprite

Interface
REQ-001 SHALL have parameter ICON_BITS, default 4, meaning log2 of icon edge; SIZE = 2**ICON_BITS, legal 3..5.
REQ-002 SHALL have parameter COLOR_W, default 2, meaning pixel colour width.
REQ-003 SHALL have parameter LOC_SHIFT, default 2, meaning world-to-pixel left shift of location.
REQ-004 SHALL have parameters OFFSET_X, default 9, and OFFSET_Y, default 4, meaning window alignment offsets in pixels.
REQ-005 SHALL have parameter ANIM_DIV_BITS, default 3, meaning animation frame toggles every 2**(ANIM_DIV_BITS-1) frame_ticks.
REQ-006 SHALL have port clock  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-008 SHALL have ports LocX_reg, LocY_reg, BotInfo_reg  input  8 each  bot location and status.
REQ-009 SHALL have ports Pixel_row, Pixel_column  input  10 each  current pixel address.
REQ-010 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-011 SHALL have ports wr_en 1, wr_addr 2*ICON_BITS+2, wr_data COLOR_W  inputs  bitmap write port; wr_addr = {frame, image, row, col}.
REQ-012 SHALL have ports icon  output  COLOR_W  pixel colour, and icon_hit  output  1  pixel inside window and non-zero.

Function
REQ-013 SHALL hold a bitmap RAM of 2 frames x 2 images (0=0 deg, 1=45 deg) x SIZE x SIZE words of COLOR_W bits.
REQ-014 SHALL write wr_data to wr_addr on a clock edge with wr_en=1; a same-cycle read of that address returns the old value.
REQ-015 SHALL compute locX = (LocX_reg << LOC_SHIFT) - OFFSET_X and locY likewise with OFFSET_Y, as 12-bit signed values.
REQ-016 SHALL treat the pixel as in-window iff 0 <= r <= S and 0 <= c <= S, with r = Pixel_row - locY, c = Pixel_column - locX (12-bit signed) and S = SIZE-1; the window never wraps, and partly off-screen icons clip.
REQ-017 SHALL map BotInfo_reg[2:0] as follows: 110 img0[r][c]; 101 img1[r][c]; 100 img0[c][S-r]; 011 img1[c][S-r]; 010 img0[S-r][S-c]; 001 img1[S-r][S-c]; 000 img0[S-c][r]; 111 img1[S-c][r].
REQ-018 SHALL pipeline in two stages: stage 1 registers the window flag and transformed RAM address; stage 2 registers RAM data into icon; latency is exactly 2 cycles from pixel inputs to icon/icon_hit.
REQ-019 SHALL drive icon=0 and icon_hit=0 when the stage-2 pixel is out of window; icon_hit = in-window AND icon != 0.
REQ-020 SHALL keep an anim counter of ANIM_DIV_BITS bits, incremented on each frame_tick while BotInfo_reg[3]=1 (moving), wrapping modulo 2**ANIM_DIV_BITS.
REQ-021 SHALL clear the anim counter to 0 on the first cycle with BotInfo_reg[3]=0 and use frame 0 while it is 0.
REQ-022 SHALL select the read frame = anim counter MSB, sampled at stage 1.
REQ-023 SHALL give frame_tick and a BotInfo_reg[3] fall in the same cycle the result clear (clear wins).

Reset
REQ-024 SHALL on rst=0 set icon=0, icon_hit=0, the anim counter to 0, all pipeline valid/window flags to 0, and any blink state to 0.
REQ-025 SHALL leave RAM contents unaltered by reset and ignore wr_en while rst=0.
REQ-026 SHALL produce a first valid output 2 cycles after rst returns to 1.

Configuration
REQ-027 SHALL, with ICON_BLINK_EN defined, keep a 5-bit blink counter incremented on each frame_tick and force icon=0 and icon_hit=0 when BotInfo_reg[7]=1 and blink counter bit 4 = 1.
REQ-028 SHALL, without ICON_BLINK_EN, contain no blink counter and ignore BotInfo_reg[7].

Verification
REQ-029 SHALL pass scenario: write img0 row 8 all 3, LocX=LocY=10, BotInfo=110, sweep row 44 / col 31..46 -> icon=3 for exactly 16 columns, 2 cycles later.
REQ-030 SHALL pass scenario: same bitmap, BotInfo=100 -> col 39 (c=8) lit for all 16 rows 36..51; row 44 shows only col 39.
REQ-031 SHALL pass scenario: LocX=0 (locX=-9) -> columns 0..6 in window (c=9..15), no hit at column 1015..1023.
REQ-032 SHALL pass scenario: BotInfo[3]=1, frame0 pixel=1, frame1 pixel=2, ANIM_DIV_BITS=3 -> output 1 for 4 ticks, then 2 for 4 ticks; dropping BotInfo[3] -> 1 next frame.
REQ-033 SHALL pass scenario: rst=0 during an active window -> icon=0/icon_hit=0 next cycle; RAM pattern intact after release.
REQ-034 SHALL pass scenario: ICON_BLINK_EN defined, BotInfo[7]=1 -> hits suppressed for ticks 16..31 of each 32; without the macro, never suppressed.

Source files
------------

// File: rtl/icon_sprite.sv
// icon_sprite: renders a SIZE x SIZE bot icon from a two-frame, two-image
// bitmap RAM, rotated in 90 degree steps according to the bot heading.
// Two-stage pipeline: window test + address transform, then RAM read.
// Optional feature macro: ICON_BLINK_EN (blinks the icon when BotInfo_reg[7]=1).
module icon_sprite #(
    parameter int ICON_BITS     = 4,
    parameter int COLOR_W       = 2,
    parameter int LOC_SHIFT     = 2,
    parameter int OFFSET_X      = 9,
    parameter int OFFSET_Y      = 4,
    parameter int ANIM_DIV_BITS = 3
) (
    input  logic                     clock,
    input  logic                     rst,
    input  logic [7:0]               LocX_reg,
    input  logic [7:0]               LocY_reg,
    input  logic [7:0]               BotInfo_reg,
    input  logic [9:0]               Pixel_row,
    input  logic [9:0]               Pixel_column,
    input  logic                     frame_tick,
    input  logic                     wr_en,
    input  logic [2*ICON_BITS+1:0]   wr_addr,
    input  logic [COLOR_W-1:0]       wr_data,
    output logic [COLOR_W-1:0]       icon,
    output logic                     icon_hit
);

    localparam int AW    = 2 * ICON_BITS + 2;
    localparam int DEPTH = 1 << AW;

    // Bitmap storage, addressed {frame, image, row, col}; never reset.
    logic [COLOR_W-1:0] mem [DEPTH];

    logic [11:0]            loc_x;
    logic [11:0]            loc_y;
    logic [11:0]            r_off;
    logic [11:0]            c_off;
    logic [ICON_BITS-1:0]   r_idx;
    logic [ICON_BITS-1:0]   c_idx;
    logic [ICON_BITS-1:0]   row_sel;
    logic [ICON_BITS-1:0]   col_sel;
    logic                   in_win;
    logic                   blank;
    logic                   unused_bits;
    logic [AW-1:0]          addr_next;
    logic [AW-1:0]          addr_reg;
    logic                   win_reg;
    logic [ANIM_DIV_BITS-1:0] anim_reg;
    logic [ANIM_DIV_BITS-1:0] anim_next;

    // Icon origin in pixel space; negative values let the icon clip off the left/top.
    assign loc_x = ({4'd0, LocX_reg} << LOC_SHIFT) - 12'(OFFSET_X);
    assign loc_y = ({4'd0, LocY_reg} << LOC_SHIFT) - 12'(OFFSET_Y);
    assign r_off = {2'd0, Pixel_row} - loc_y;
    assign c_off = {2'd0, Pixel_column} - loc_x;

    // Inside the window exactly when both offsets lie in 0..SIZE-1, i.e. all
    // bits above the icon index (including the sign) are zero.
    assign in_win = (r_off[11:ICON_BITS] == '0) && (c_off[11:ICON_BITS] == '0);
    assign r_idx  = r_off[ICON_BITS-1:0];
    assign c_idx  = c_off[ICON_BITS-1:0];

    // Heading decode: rotate the read coordinates; S-x is the bitwise inverse of x.
    always_comb begin
        row_sel = r_idx;
        col_sel = c_idx;
        case (BotInfo_reg[2:0])
            3'b110, 3'b101: begin
                row_sel = r_idx;
                col_sel = c_idx;
            end
            3'b100, 3'b011: begin
                row_sel = c_idx;
                col_sel = ~r_idx;
            end
            3'b010, 3'b001: begin
                row_sel = ~r_idx;
                col_sel = ~c_idx;
            end
            default: begin
                row_sel = ~c_idx;
                col_sel = r_idx;
            end
        endcase
    end

    // Image 1 (45 degree art) is used for every heading with bit 0 set.
    assign addr_next = {anim_reg[ANIM_DIV_BITS-1], BotInfo_reg[0], row_sel, col_sel};

    // Animation step: clearing when the bot stops takes priority over a tick.
    always_comb begin
        anim_next = anim_reg;
        if (!BotInfo_reg[3]) begin
            anim_next = '0;
        end else if (frame_tick) begin
            anim_next = anim_reg + 1'b1;
        end
    end

    // Animation counter register.
    always_ff @(posedge clock) begin
        if (!rst) begin
            anim_reg <= '0;
        end else begin
            anim_reg <= anim_next;
        end
    end

`ifdef ICON_BLINK_EN
    logic [4:0] blink_reg;

    // Free-running blink counter; upper half of its period blanks flagged bots.
    always_ff @(posedge clock) begin
        if (!rst) begin
            blink_reg <= '0;
        end else if (frame_tick) begin
            blink_reg <= blink_reg + 5'd1;
        end
    end

    assign blank       = BotInfo_reg[7] & blink_reg[4];
    assign unused_bits = ^BotInfo_reg[6:4];
`else
    assign blank       = 1'b0;
    assign unused_bits = ^BotInfo_reg[7:4];
`endif

    // Bitmap write port; writes are locked out while reset is asserted.
    always_ff @(posedge clock) begin
        if (wr_en && rst) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Stage 1: register the window flag and the rotated RAM address.
    always_ff @(posedge clock) begin
        if (!rst) begin
            win_reg  <= 1'b0;
            addr_reg <= '0;
        end else begin
            win_reg  <= in_win & ~blank;
            addr_reg <= addr_next;
        end
    end

    // Stage 2: registered RAM read, gated to zero outside the window.
    always_ff @(posedge clock) begin
        if (!rst) begin
            icon     <= '0;
            icon_hit <= 1'b0;
        end else if (win_reg) begin
            icon     <= mem[addr_reg];
            icon_hit <= |mem[addr_reg];
        end else begin
            icon     <= '0;
            icon_hit <= 1'b0;
        end
    end

endmodule

// File: tb/tb_icon_sprite.sv
// Directed testbench for icon_sprite (default parameters).
module tb_icon_sprite;

    logic        clock = 1'b0;
    logic        rst;
    logic [7:0]  LocX_reg;
    logic [7:0]  LocY_reg;
    logic [7:0]  BotInfo_reg;
    logic [9:0]  Pixel_row;
    logic [9:0]  Pixel_column;
    logic        frame_tick;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [1:0]  wr_data;
    logic [1:0]  icon;
    logic        icon_hit;

    int n_checks = 0;
    int n_fail   = 0;
    int blink_model = 0;

    // Orientation table: heading, r, c, expected colour (bitmap loaded by load_bitmap)
    int rot_bot [16] = '{6, 6, 4, 4, 2, 2, 0, 0, 5, 5, 3, 3, 1, 1, 7, 7};
    int rot_r   [16] = '{8, 9, 0, 8, 7, 8, 3, 7, 2, 8, 10, 2, 13, 2, 5, 2};
    int rot_c   [16] = '{4, 4, 8, 9, 0, 0, 7, 3, 5, 4, 2, 10, 10, 5, 13, 5};
    int rot_exp [16] = '{3, 0, 3, 0, 3, 0, 3, 0, 1, 0, 1, 0, 1, 0, 1, 0};

    icon_sprite dut (
        .clock        (clock),
        .rst          (rst),
        .LocX_reg     (LocX_reg),
        .LocY_reg     (LocY_reg),
        .BotInfo_reg  (BotInfo_reg),
        .Pixel_row    (Pixel_row),
        .Pixel_column (Pixel_column),
        .frame_tick   (frame_tick),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .icon         (icon),
        .icon_hit     (icon_hit)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_px(input logic fr, input logic img, input int row, input int col,
                            input logic [1:0] d);
        wr_addr = {fr, img, 4'(row), 4'(col)};
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_tick();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        blink_model++;
    endtask

    task automatic show(input int row, input int col);
        Pixel_row    = 10'(row);
        Pixel_column = 10'(col);
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) tick();
        n_checks++;
        if (icon !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_icon: got %0d expected 0", icon);
        end
        n_checks++;
        if (icon_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hit: got %0d expected 0", icon_hit);
        end
        rst = 1'b1;
        blink_model = 0;
        $display("reset: icon=%0d hit=%0d", icon, icon_hit);
    endtask

    task automatic load_bitmap();
        for (int a = 0; a < 1024; a++) begin
            wr_addr = 10'(a);
            wr_data = 2'd0;
            wr_en   = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        for (int c = 0; c < 16; c++) write_px(1'b0, 1'b0, 8, c, 2'd3);
        write_px(1'b0, 1'b1, 2, 5, 2'd1);
        write_px(1'b0, 1'b0, 0, 0, 2'd1);
        write_px(1'b1, 1'b0, 0, 0, 2'd2);
        $display("bitmap loaded");
    endtask

    task automatic test_identity();
        LocX_reg = 8'd10;
        LocY_reg = 8'd10;
        BotInfo_reg = 8'h06;
        for (int col = 30; col <= 47; col++) begin
            int e;
            e = (col >= 31 && col <= 46) ? 3 : 0;
            show(44, col);
            n_checks++;
            if (icon !== 2'(e)) begin
                n_fail++;
                $display("FAIL identity_icon col %0d: got %0d expected %0d", col, icon, e);
            end
            n_checks++;
            if (icon_hit !== (e != 0)) begin
                n_fail++;
                $display("FAIL identity_hit col %0d: got %0d expected %0d", col, icon_hit, e != 0);
            end
            $display("identity row 44 col %0d: icon=%0d hit=%0d", col, icon, icon_hit);
        end
    endtask

    task automatic test_rotations();
        LocX_reg = 8'd10;
        LocY_reg = 8'd10;
        for (int i = 0; i < 16; i++) begin
            BotInfo_reg = 8'(rot_bot[i]);
            show(36 + rot_r[i], 31 + rot_c[i]);
            n_checks++;
            if (icon !== 2'(rot_exp[i])) begin
                n_fail++;
                $display("FAIL rotate bot %0d r %0d c %0d: got %0d expected %0d",
                         rot_bot[i], rot_r[i], rot_c[i], icon, rot_exp[i]);
            end
            $display("rotate bot=%0d r=%0d c=%0d: icon=%0d", rot_bot[i], rot_r[i], rot_c[i], icon);
        end
        BotInfo_reg = 8'h04;
        for (int row = 35; row <= 52; row++) begin
            int e;
            e = (row >= 36 && row <= 51) ? 3 : 0;
            show(row, 39);
            n_checks++;
            if (icon !== 2'(e)) begin
                n_fail++;
                $display("FAIL rot90_column row %0d: got %0d expected %0d", row, icon, e);
            end
            $display("rot90 col 39 row %0d: icon=%0d", row, icon);
        end
        for (int col = 31; col <= 46; col++) begin
            int e;
            e = (col == 39) ? 3 : 0;
            show(44, col);
            n_checks++;
            if (icon_hit !== (e != 0)) begin
                n_fail++;
                $display("FAIL rot90_row col %0d: got %0d expected %0d", col, icon_hit, e != 0);
            end
            $display("rot90 row 44 col %0d: hit=%0d", col, icon_hit);
        end
    endtask

    task automatic test_clip();
        LocX_reg = 8'd0;
        LocY_reg = 8'd10;
        BotInfo_reg = 8'h06;
        for (int col = 0; col <= 7; col++) begin
            int e;
            e = (col <= 6) ? 3 : 0;
            show(44, col);
            n_checks++;
            if (icon !== 2'(e) || icon_hit !== (e != 0)) begin
                n_fail++;
                $display("FAIL clip col %0d: got icon %0d hit %0d expected icon %0d", col, icon, icon_hit, e);
            end
            $display("clip col %0d: icon=%0d hit=%0d", col, icon, icon_hit);
        end
        for (int col = 1015; col <= 1023; col++) begin
            show(44, col);
            n_checks++;
            if (icon_hit !== 1'b0 || icon !== 2'd0) begin
                n_fail++;
                $display("FAIL clip_wrap col %0d: got icon %0d hit %0d expected 0", col, icon, icon_hit);
            end
            $display("clip col %0d: icon=%0d hit=%0d", col, icon, icon_hit);
        end
    endtask

    task automatic test_back_to_back();
        LocX_reg = 8'd10;
        LocY_reg = 8'd10;
        BotInfo_reg = 8'h06;
        Pixel_row = 10'd44;
        for (int i = 0; i < 22; i++) begin
            Pixel_column = 10'(28 + i);
            tick();
            if (i >= 1) begin
                int col;
                int e;
                col = 28 + i - 1;
                e = (col >= 31 && col <= 46) ? 3 : 0;
                n_checks++;
                if (icon !== 2'(e)) begin
                    n_fail++;
                    $display("FAIL stream col %0d: got %0d expected %0d", col, icon, e);
                end
                $display("stream col %0d: icon=%0d", col, icon);
            end
        end
    endtask

    task automatic test_anim();
        LocX_reg = 8'd10;
        LocY_reg = 8'd10;
        BotInfo_reg = 8'h0E;
        show(36, 31);
        for (int t = 0; t < 10; t++) begin
            int e;
            e = ((t % 8) < 4) ? 1 : 2;
            n_checks++;
            if (icon !== 2'(e)) begin
                n_fail++;
                $display("FAIL anim tick %0d: got %0d expected %0d", t, icon, e);
            end
            $display("anim after %0d ticks: icon=%0d", t, icon);
            pulse_tick();
            tick();
            tick();
        end
        // ten ticks so far -> counter 2; two more reach 4 (frame 1)
        pulse_tick();
        pulse_tick();
        tick();
        tick();
        n_checks++;
        if (icon !== 2'd2) begin
            n_fail++;
            $display("FAIL anim_frame1: got %0d expected 2", icon);
        end
        $display("anim at count 4: icon=%0d", icon);
        // stop and tick in the same cycle: the clear must win
        frame_tick = 1'b1;
        BotInfo_reg = 8'h06;
        tick();
        blink_model++;
        frame_tick = 1'b0;
        BotInfo_reg = 8'h0E;
        tick();
        tick();
        n_checks++;
        if (icon !== 2'd1) begin
            n_fail++;
            $display("FAIL anim_clear_wins: got %0d expected 1", icon);
        end
        $display("anim after stop+tick: icon=%0d", icon);
        BotInfo_reg = 8'h06;
        tick();
    endtask

    task automatic test_reset_during();
        LocX_reg = 8'd10;
        LocY_reg = 8'd10;
        BotInfo_reg = 8'h06;
        show(44, 34);
        n_checks++;
        if (icon !== 2'd3) begin
            n_fail++;
            $display("FAIL pre_reset_icon: got %0d expected 3", icon);
        end
        rst = 1'b0;
        wr_addr = 10'd0;
        wr_data = 2'd3;
        wr_en = 1'b1;
        tick();
        n_checks++;
        if (icon !== 2'd0 || icon_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_out: got icon %0d hit %0d expected 0 0", icon, icon_hit);
        end
        wr_en = 1'b0;
        tick();
        rst = 1'b1;
        blink_model = 0;
        tick();
        n_checks++;
        if (icon !== 2'd0) begin
            n_fail++;
            $display("FAIL release_latency1: got %0d expected 0", icon);
        end
        tick();
        n_checks++;
        if (icon !== 2'd3 || icon_hit !== 1'b1) begin
            n_fail++;
            $display("FAIL release_latency2: got icon %0d hit %0d expected 3 1", icon, icon_hit);
        end
        show(36, 31);
        n_checks++;
        if (icon !== 2'd1) begin
            n_fail++;
            $display("FAIL ram_kept_in_reset: got %0d expected 1", icon);
        end
        $display("reset during window: post-release word0=%0d", icon);
    endtask

    task automatic test_blink();
        LocX_reg = 8'd10;
        LocY_reg = 8'd10;
        BotInfo_reg = 8'h86;
        show(44, 34);
        for (int k = 0; k < 34; k++) begin
            logic blank_exp;
`ifdef ICON_BLINK_EN
            blank_exp = ((blink_model % 32) >= 16);
`else
            blank_exp = 1'b0;
`endif
            n_checks++;
            if (icon_hit !== !blank_exp || icon !== (blank_exp ? 2'd0 : 2'd3)) begin
                n_fail++;
                $display("FAIL blink tick %0d: got icon %0d hit %0d expected hit %0d",
                         blink_model, icon, icon_hit, !blank_exp);
            end
            $display("blink count %0d: icon=%0d hit=%0d", blink_model, icon, icon_hit);
            pulse_tick();
            tick();
            tick();
        end
    endtask

    initial begin
        rst = 1'b0;
        LocX_reg = 8'd0;
        LocY_reg = 8'd0;
        BotInfo_reg = 8'd0;
        Pixel_row = 10'd0;
        Pixel_column = 10'd0;
        frame_tick = 1'b0;
        wr_en = 1'b0;
        wr_addr = 10'd0;
        wr_data = 2'd0;
        #1;
        test_reset();
        load_bitmap();
        test_identity();
        test_rotations();
        test_clip();
        test_back_to_back();
        test_anim();
        test_reset_during();
        test_blink();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
